// File: rtl/reaction_pkg.sv
// Shared types and default sizes for the reaction-timer controller.
package reaction_pkg;

    localparam int N_LIGHTS_DEF = 10;
    localparam int MAX_MS_DEF   = 9999;
    localparam int MS_W_DEF     = 14;

    typedef logic [MS_W_DEF-1:0] ms_t;

    typedef enum logic [2:0] {
        IDLE,
        LIGHTS,
        HOLD,
        GO,
        DONE,
        FAULT
    } state_t;

endpackage

// File: rtl/reaction_ctrl_ms_counter.sv
// Loadable up/down millisecond counter shared by the hold-off countdown and
// the reaction-time count-up; saturates at MAX_MS going up and at 0 going down.
module ms_counter
    import reaction_pkg::*;
#(
    parameter int MS_W   = MS_W_DEF,
    parameter int MAX_MS = MAX_MS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [MS_W-1:0] load_val,
    input  logic            en,
    input  logic            up,
    output logic [MS_W-1:0] count,
    output logic            zero
);

    logic [MS_W-1:0] count_q;
    logic [MS_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (up) begin
                if (count_q < MS_W'(MAX_MS)) begin
                    count_d = count_q + 1'b1;
                end
            end else if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/reaction_ctrl.sv
// Round sequencer for the reaction timer: start lights, random hold-off,
// reaction measurement, false-start detection and best-time record.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int N_LIGHTS = N_LIGHTS_DEF,
    parameter int MAX_MS   = MAX_MS_DEF,
    parameter int MS_W     = MS_W_DEF
) (
    input  logic                CLOCK_50,
    input  logic                rst_n,
    input  logic                tick_1ms,
    input  logic                tick_500ms,
    input  logic                start,
    input  logic                react,
    input  logic [MS_W-1:0]     rand_ms,
    output logic                lfsr_en,
    output logic [N_LIGHTS-1:0] ledr,
    output logic [MS_W-1:0]     result_ms,
    output logic                result_valid,
    output logic [MS_W-1:0]     best_ms,
    output logic                false_start,
    output logic                busy
);

    localparam int LC_W = $clog2(N_LIGHTS + 1);

    state_t              state_q, state_d;
    logic [N_LIGHTS-1:0] ledr_q, ledr_d;
    logic [LC_W-1:0]     light_cnt_q, light_cnt_d;
    logic [MS_W-1:0]     result_q, result_d;
    logic [MS_W-1:0]     best_q, best_d;
    logic                result_valid_q, result_valid_d;
    logic                false_start_q, false_start_d;
    logic                lfsr_en_q, lfsr_en_d;
    logic                busy_q, busy_d;

    logic                cnt_load;
    logic [MS_W-1:0]     cnt_load_val;
    logic                cnt_en;
    logic                cnt_up;
    logic [MS_W-1:0]     cnt_value;
    logic                cnt_zero;

    ms_counter #(
        .MS_W   (MS_W),
        .MAX_MS (MAX_MS)
    ) u_ms_counter (
        .clk      (CLOCK_50),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .count    (cnt_value),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d        = state_q;
        ledr_d         = ledr_q;
        light_cnt_d    = light_cnt_q;
        result_d       = result_q;
        best_d         = best_q;
        result_valid_d = result_valid_q;
        false_start_d  = false_start_q;
        cnt_load       = 1'b0;
        cnt_load_val   = '0;
        cnt_en         = 1'b0;
        cnt_up         = 1'b0;

        case (state_q)
            IDLE, DONE, FAULT: begin
                // start outranks a simultaneous react in every resting state
                if (start) begin
                    state_d        = LIGHTS;
                    ledr_d         = '0;
                    light_cnt_d    = '0;
                    result_valid_d = 1'b0;
                    false_start_d  = 1'b0;
                    cnt_load       = 1'b1;
                end else if (state_q == FAULT && tick_500ms) begin
                    ledr_d = ~ledr_q;
                end
            end
            LIGHTS: begin
                if (react) begin
                    state_d        = FAULT;
                    false_start_d  = 1'b1;
                    result_valid_d = 1'b0;
                    ledr_d         = '1;
                end else if (tick_500ms) begin
                    ledr_d      = {ledr_q[N_LIGHTS-2:0], 1'b1};
                    light_cnt_d = light_cnt_q + 1'b1;
                    if (light_cnt_q == LC_W'(N_LIGHTS - 1)) begin
                        state_d      = HOLD;
                        cnt_load     = 1'b1;
                        cnt_load_val = rand_ms;
                    end
                end
            end
            HOLD: begin
                if (react) begin
                    state_d        = FAULT;
                    false_start_d  = 1'b1;
                    result_valid_d = 1'b0;
                    ledr_d         = '1;
                end else if (tick_1ms) begin
                    if (cnt_zero) begin
                        state_d  = GO;
                        ledr_d   = '0;
                        cnt_load = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            GO: begin
                // react is judged on the count before any same-cycle tick
                if (react) begin
                    state_d        = DONE;
                    result_d       = cnt_value;
                    result_valid_d = 1'b1;
                    if (cnt_value < best_q) begin
                        best_d = cnt_value;
                    end
                end else if (tick_1ms) begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b1;
                    if (cnt_value >= MS_W'(MAX_MS - 1)) begin
                        state_d        = DONE;
                        result_d       = MS_W'(MAX_MS);
                        result_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ledr_d  = '0;
            end
        endcase

        lfsr_en_d = (state_d == IDLE) || (state_d == DONE) || (state_d == FAULT);
        busy_d    = (state_d == LIGHTS) || (state_d == HOLD) || (state_d == GO);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ledr_q         <= '0;
            light_cnt_q    <= '0;
            result_q       <= '0;
            best_q         <= MS_W'(MAX_MS);
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            lfsr_en_q      <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ledr_q         <= ledr_d;
            light_cnt_q    <= light_cnt_d;
            result_q       <= result_d;
            best_q         <= best_d;
            result_valid_q <= result_valid_d;
            false_start_q  <= false_start_d;
            lfsr_en_q      <= lfsr_en_d;
            busy_q         <= busy_d;
        end
    end

    assign lfsr_en      = lfsr_en_q;
    assign ledr         = ledr_q;
    assign result_ms    = result_q;
    assign result_valid = result_valid_q;
    assign best_ms      = best_q;
    assign false_start  = false_start_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl: table of scripted rounds, randomized
// rounds scored by a round-level model, and hand-written corner sequences.
module tb_reaction_ctrl;
    import reaction_pkg::*;

    localparam int N    = 10;
    localparam int MAXV = 9999;
    localparam int ALL  = (1 << N) - 1;

    logic         CLOCK_50 = 1'b0;
    logic         rst_n;
    logic         tick_1ms;
    logic         tick_500ms;
    logic         start;
    logic         react;
    ms_t          rand_ms;
    logic         lfsr_en;
    logic [N-1:0] ledr;
    ms_t          result_ms;
    logic         result_valid;
    ms_t          best_ms;
    logic         false_start;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int modelBest;
    int modelLast;

    typedef struct {
        int randMs;
        int faultLights;
        int reactAt;
        bit coincide;
        int expResult;
        int expBest;
        bit expFalse;
    } vec_t;

    vec_t vecs[5];

    reaction_ctrl dut (
        .CLOCK_50     (CLOCK_50),
        .rst_n        (rst_n),
        .tick_1ms     (tick_1ms),
        .tick_500ms   (tick_500ms),
        .start        (start),
        .react        (react),
        .rand_ms      (rand_ms),
        .lfsr_en      (lfsr_en),
        .ledr         (ledr),
        .result_ms    (result_ms),
        .result_valid (result_valid),
        .best_ms      (best_ms),
        .false_start  (false_start),
        .busy         (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock with the given pulses; outputs are sampled 1 ns after the edge
    task automatic applyStimulus(input bit t1, input bit t5, input bit st, input bit re);
        tick_1ms   = t1;
        tick_500ms = t5;
        start      = st;
        react      = re;
        @(posedge CLOCK_50);
        #1;
        tick_1ms   = 1'b0;
        tick_500ms = 1'b0;
        start      = 1'b0;
        react      = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_lfsr_en"}, int'(lfsr_en), 1);
        checkOutput({tag, "_ledr"}, int'(ledr), 0);
        checkOutput({tag, "_result_ms"}, int'(result_ms), 0);
        checkOutput({tag, "_result_valid"}, int'(result_valid), 0);
        checkOutput({tag, "_false_start"}, int'(false_start), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_best_ms"}, int'(best_ms), MAXV);
    endtask

    // A full round. faultLights >= 0 means react after that many lights;
    // reactAt < 0 means never react (timeout).
    task automatic runRound(input int randMs, input int faultLights, input int reactAt,
                            input bit coincide, input bit fault500,
                            input int expResult, input int expBest, input bit expFalse);
        int n;
        rand_ms = ms_t'(randMs);
        applyStimulus(0, 0, 1, 0);
        checkOutput("start_busy", int'(busy), 1);
        checkOutput("start_lfsr_en", int'(lfsr_en), 0);
        checkOutput("start_ledr", int'(ledr), 0);
        checkOutput("start_false_start", int'(false_start), 0);
        checkOutput("start_result_valid", int'(result_valid), 0);
        for (int k = 1; k <= N; k++) begin
            if (k - 1 == faultLights) break;
            applyStimulus(1, 1, 0, 0);
            checkOutput("light_bar", int'(ledr), (1 << k) - 1);
        end
        if (faultLights >= 0) begin
            if (fault500) applyStimulus(1, 1, 0, 1);
            else applyStimulus(0, 0, 0, 1);
            checkOutput("fault_false_start", int'(false_start), int'(expFalse));
            checkOutput("fault_result_valid", int'(result_valid), 0);
            checkOutput("fault_ledr_on", int'(ledr), ALL);
            checkOutput("fault_lfsr_en", int'(lfsr_en), 1);
            checkOutput("fault_busy", int'(busy), 0);
            checkOutput("fault_result_ms", int'(result_ms), expResult);
            checkOutput("fault_best_ms", int'(best_ms), expBest);
            applyStimulus(1, 1, 0, 0);
            checkOutput("flash_off", int'(ledr), 0);
            applyStimulus(1, 0, 0, 0);
            checkOutput("flash_hold_1ms", int'(ledr), 0);
            applyStimulus(1, 1, 0, 0);
            checkOutput("flash_on", int'(ledr), ALL);
            return;
        end
        checkOutput("hold_lfsr_en", int'(lfsr_en), 0);
        n = 0;
        while (ledr != '0 && n < 20000) begin
            applyStimulus(1, 0, 0, 0);
            n++;
        end
        checkOutput("hold_ticks", n, randMs + 1);
        checkOutput("go_busy", int'(busy), 1);
        if (reactAt < 0) begin
            n = 0;
            while (!result_valid && n < 10100) begin
                applyStimulus(1, 0, 0, 0);
                n++;
                if (n == 100) begin
                    applyStimulus(0, 0, 1, 0);
                    checkOutput("start_ignored_go_busy", int'(busy), 1);
                    checkOutput("start_ignored_go_ledr", int'(ledr), 0);
                end
            end
            checkOutput("timeout_ticks", n, MAXV);
        end else begin
            for (int i = 0; i < reactAt; i++) applyStimulus(1, 0, 0, 0);
            if (coincide) applyStimulus(1, 0, 0, 1);
            else applyStimulus(0, 0, 0, 1);
        end
        checkOutput("done_result_ms", int'(result_ms), expResult);
        checkOutput("done_result_valid", int'(result_valid), 1);
        checkOutput("done_best_ms", int'(best_ms), expBest);
        checkOutput("done_false_start", int'(false_start), 0);
        checkOutput("done_busy", int'(busy), 0);
        checkOutput("done_lfsr_en", int'(lfsr_en), 1);
        checkOutput("done_ledr", int'(ledr), 0);
    endtask

    initial begin
        int randMs, faultLights, reactAt, expResult;
        bit coincide, fault500, isFault;

        vecs[0] = '{randMs: 250, faultLights: -1, reactAt: 173, coincide: 0,
                    expResult: 173, expBest: 173, expFalse: 0};
        vecs[1] = '{randMs: 120, faultLights: -1, reactAt: 200, coincide: 0,
                    expResult: 200, expBest: 173, expFalse: 0};
        vecs[2] = '{randMs: 7, faultLights: -1, reactAt: 90, coincide: 0,
                    expResult: 90, expBest: 90, expFalse: 0};
        vecs[3] = '{randMs: 50, faultLights: 3, reactAt: 0, coincide: 0,
                    expResult: 90, expBest: 90, expFalse: 1};
        vecs[4] = '{randMs: 0, faultLights: -1, reactAt: 42, coincide: 1,
                    expResult: 42, expBest: 42, expFalse: 0};

        rst_n      = 1'b0;
        tick_1ms   = 1'b0;
        tick_500ms = 1'b0;
        start      = 1'b0;
        react      = 1'b0;
        rand_ms    = '0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
        checkResetValues("reset");

        applyStimulus(1, 1, 0, 1);
        checkOutput("idle_react_ignored_busy", int'(busy), 0);
        checkOutput("idle_react_ignored_fs", int'(false_start), 0);
        checkOutput("idle_react_ignored_lfsr", int'(lfsr_en), 1);

        foreach (vecs[i]) begin
            runRound(vecs[i].randMs, vecs[i].faultLights, vecs[i].reactAt, vecs[i].coincide, 0,
                     vecs[i].expResult, vecs[i].expBest, vecs[i].expFalse);
        end

        // Round-level model: best is the minimum of completed reactions,
        // a false start leaves both the last result and the best untouched.
        modelBest = 42;
        modelLast = 42;
        for (int r = 0; r < 16; r++) begin
            randMs      = int'($urandom_range(0, 200));
            isFault     = ($urandom_range(0, 3) == 0);
            faultLights = isFault ? int'($urandom_range(0, N - 1)) : -1;
            reactAt     = int'($urandom_range(1, 300));
            coincide    = 1'($urandom_range(0, 1));
            fault500    = 1'($urandom_range(0, 1));
            if (isFault) begin
                expResult = modelLast;
            end else begin
                expResult = reactAt;
                modelLast = reactAt;
                if (reactAt < modelBest) modelBest = reactAt;
            end
            runRound(randMs, faultLights, reactAt, coincide, fault500,
                     expResult, modelBest, isFault);
        end

        runRound(5, -1, -1, 0, 0, MAXV, modelBest, 0);

        applyStimulus(0, 0, 1, 1);
        checkOutput("done_start_react_busy", int'(busy), 1);
        checkOutput("done_start_react_fs", int'(false_start), 0);
        checkOutput("done_start_react_valid", int'(result_valid), 0);

        rand_ms = ms_t'(3);
        for (int k = 0; k < N; k++) applyStimulus(1, 1, 0, 0);
        for (int k = 0; k < 4 + 5; k++) applyStimulus(1, 0, 0, 0);
        checkOutput("pre_reset_in_go_busy", int'(busy), 1);
        checkOutput("pre_reset_in_go_ledr", int'(ledr), 0);
        rst_n = 1'b0;
        #1;
        checkResetValues("midgo_reset");
        @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0);
        checkResetValues("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
